// File: rtl/fpu_pipe_pkg.sv
// Shared types and helpers for the FPU elastic pipeline register.
package fpu_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    function automatic int occ_width(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/fpu_skid_stage.sv
// One elastic stage: a main register feeding downstream plus a skid entry,
// so up_ready depends only on registered state.
module fpu_skid_stage
    import fpu_pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [WIDTH-1:0] down_data,
    output logic             push,
    output logic             pop
);

    stage_state_t     state_r, state_nxt_s;
    logic [WIDTH-1:0] main_r, main_nxt_s;
    logic [WIDTH-1:0] skid_r, skid_nxt_s;

    assign up_ready   = (state_r != FULL);
    assign down_valid = (state_r != EMPTY);
    assign down_data  = main_r;
    assign push       = up_valid & up_ready;
    assign pop        = down_valid & down_ready;

    // Next-state and data-register selection; flush empties without touching data.
    always_comb begin
        state_nxt_s = state_r;
        main_nxt_s  = main_r;
        skid_nxt_s  = skid_r;
        if (flush) begin
            state_nxt_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (push) begin
                        state_nxt_s = ONE;
                        main_nxt_s  = up_data;
                    end else begin
                        state_nxt_s = EMPTY;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state_nxt_s = FULL;
                        skid_nxt_s  = up_data;
                    end else if (!push && pop) begin
                        state_nxt_s = EMPTY;
                    end else if (push && pop) begin
                        state_nxt_s = ONE;
                        main_nxt_s  = up_data;
                    end else begin
                        state_nxt_s = ONE;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_nxt_s = ONE;
                        main_nxt_s  = skid_r;
                    end else begin
                        state_nxt_s = FULL;
                    end
                end
                default: begin
                    state_nxt_s = EMPTY;
                end
            endcase
        end
    end

    // State and data registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= EMPTY;
            main_r  <= RESET_VAL;
            skid_r  <= RESET_VAL;
        end else begin
            state_r <= state_nxt_s;
            main_r  <= main_nxt_s;
            skid_r  <= skid_nxt_s;
        end
    end

endmodule

// File: rtl/fpu_pipe_reg.sv
// Chain of STAGES elastic stages with flush and a registered occupancy count.
module fpu_pipe_reg
    import fpu_pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic [occ_width(STAGES)-1:0]   occupancy
);

    localparam int OCC_W = occ_width(STAGES);

    logic             vld_s  [STAGES+1];
    logic             rdy_s  [STAGES+1];
    logic [WIDTH-1:0] dat_s  [STAGES+1];
    logic             push_s [STAGES];
    logic             pop_s  [STAGES];

    logic [OCC_W-1:0] occ_r, occ_nxt_s, push_cnt_s, pop_cnt_s;

    assign vld_s[0]      = in_valid & ~flush;
    assign dat_s[0]      = in_data;
    assign rdy_s[STAGES] = out_ready;

    assign in_ready  = rdy_s[0] & ~flush;
    assign out_valid = vld_s[STAGES];
    assign out_data  = dat_s[STAGES];
    assign occupancy = occ_r;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        fpu_skid_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .flush      (flush),
            .up_valid   (vld_s[k]),
            .up_ready   (rdy_s[k]),
            .up_data    (dat_s[k]),
            .down_valid (vld_s[k+1]),
            .down_ready (rdy_s[k+1]),
            .down_data  (dat_s[k+1]),
            .push       (push_s[k]),
            .pop        (pop_s[k])
        );
    end

    // Net word count change; internal hand-offs appear once as a push and once as a pop and cancel.
    always_comb begin
        push_cnt_s = '0;
        pop_cnt_s  = '0;
        occ_nxt_s  = occ_r;
        for (int k = 0; k < STAGES; k++) begin
            push_cnt_s = push_cnt_s + {{(OCC_W-1){1'b0}}, push_s[k]};
            pop_cnt_s  = pop_cnt_s  + {{(OCC_W-1){1'b0}}, pop_s[k]};
        end
        if (flush) begin
            occ_nxt_s = '0;
        end else begin
            occ_nxt_s = occ_r + push_cnt_s - pop_cnt_s;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_r <= '0;
        end else begin
            occ_r <= occ_nxt_s;
        end
    end

endmodule

// File: tb/tb_fpu_pipe_reg.sv
// Scoreboard bench for fpu_pipe_reg (WIDTH=32, STAGES=2, RESET_VAL=0).
module tb_fpu_pipe_reg;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;
    localparam int OW     = $clog2(2 * STAGES + 1);

    logic             clk = 1'b0;
    logic             reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [WIDTH-1:0] in_data, out_data;
    logic [OW-1:0]    occupancy;

    always #5 clk = ~clk;

    fpu_pipe_reg #(.WIDTH(WIDTH), .STAGES(STAGES), .RESET_VAL('0)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    typedef struct {
        logic [WIDTH-1:0] data;
        int               cyc;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             mon_e;
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    bit               lat_chk = 1'b0;
    bit               stall_prev = 1'b0;
    logic [WIDTH-1:0] held;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard bookkeeping at the active edge: compare pops, record accepts.
    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %0h expected no word (t=%0t)", out_data, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data_order", out_data, mon_e.data);
                    if (lat_chk) check("latency", cyc - mon_e.cyc, 2);
                end
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back('{in_data, cyc});
        end
    end

    // Mid-cycle checks: occupancy vs scoreboard depth, stall stability, ready bounds.
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            check("occ_vs_depth", occupancy, exp_q.size());
            if (stall_prev) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_data", out_data, held);
            end
            if (!flush) begin
                if (exp_q.size() <= 2) check("ready_when_room", in_ready, 1'b1);
                else if (exp_q.size() == 4) check("ready_when_full", in_ready, 1'b0);
            end
            stall_prev = out_valid && !out_ready;
            held       = out_data;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] d;
        logic             acc;
        int               w, tmo, k;
        bit [5:0]         pat;

        pat      = 6'b001101;
        reset    = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'h0;
        out_ready = 1'b0;

        // Reset values, observed before any clock edge
        #3;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_occupancy", occupancy, 3'd0);
        check("rst_in_ready", in_ready, 1'b1);
        #4 reset = 1'b0;
        step();

        // Streaming at full rate
        out_ready = 1'b1;
        lat_chk   = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = i;
            step();
            if (i == 5) begin
                @(negedge clk);
                check("stream_occ", occupancy, 3'd2);
            end
        end
        in_valid = 1'b0;
        repeat (4) step();
        lat_chk = 1'b0;
        check("stream_drained", exp_q.size(), 0);

        // Backpressure: only four words fit
        out_ready = 1'b0;
        in_valid  = 1'b1;
        d         = 32'hA0;
        repeat (8) begin
            in_data = d;
            @(negedge clk);
            acc = in_ready;
            step();
            if (acc) d = d + 32'd1;
        end
        @(negedge clk);
        check("bp_accepted", d, 32'hA4);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_occupancy", occupancy, 3'd4);
        check("bp_out_data", out_data, 32'hA0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        @(negedge clk);
        check("bp_ready_still_low", in_ready, 1'b0);
        step();
        @(negedge clk);
        check("bp_ready_back", in_ready, 1'b1);
        repeat (4) step();
        check("bp_drained", exp_q.size(), 0);

        // Random in_valid with repeating out_ready pattern
        w   = 0;
        tmo = 0;
        k   = 0;
        while (w < 1000 && tmo < 20000) begin
            out_ready = pat[k % 6];
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 32'h1000_0000 + w;
            @(negedge clk);
            acc = in_valid & in_ready;
            step();
            if (acc) w++;
            k++;
            tmo++;
        end
        check("rand_words_sent", w, 1000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tmo = 0;
        while (exp_q.size() != 0 && tmo < 20) begin
            step();
            tmo++;
        end
        check("rand_drained", exp_q.size(), 0);

        // Flush with three words held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 32'h11; step();
        in_data = 32'h22; step();
        in_data = 32'h33; step();
        flush     = 1'b1;
        in_data   = 32'h55;
        out_ready = 1'b1;
        @(negedge clk);
        check("flush_pre_occ", occupancy, 3'd3);
        check("flush_in_ready", in_ready, 1'b0);
        check("flush_head", out_data, 32'h11);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_occ", occupancy, 3'd0);
        check("flush_out_valid", out_valid, 1'b0);
        repeat (3) step();
        check("flush_nothing_left", exp_q.size(), 0);

        // Asynchronous reset with four words held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'hB0 + i;
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_occ", occupancy, 3'd4);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_out_valid", out_valid, 1'b0);
        check("async_out_data", out_data, 32'h0);
        check("async_occupancy", occupancy, 3'd0);
        check("async_in_ready", in_ready, 1'b1);
        exp_q.delete();
        #4 reset = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h77;
        out_ready = 1'b1;
        lat_chk   = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        @(negedge clk);
        check("post_reset_valid", out_valid, 1'b1);
        check("post_reset_data", out_data, 32'h77);
        step();
        lat_chk = 1'b0;
        repeat (2) step();
        check("post_reset_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
